// File: rtl/alu_pkg.sv
// alu_pkg: function codes, unit selects and compare constants shared by
// the registered ALU and its unit decoder.
package alu_pkg;

    // Arithmetic unit codes
    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0001;
    localparam logic [3:0] FN_MUL   = 4'b0010;
    localparam logic [3:0] FN_DIV   = 4'b0011;

    // Logic unit codes
    localparam logic [3:0] FN_AND   = 4'b0100;
    localparam logic [3:0] FN_OR    = 4'b0101;
    localparam logic [3:0] FN_NAND  = 4'b0110;
    localparam logic [3:0] FN_NOR   = 4'b0111;

    // Compare unit codes
    localparam logic [3:0] FN_NOP   = 4'b1000;
    localparam logic [3:0] FN_EQ    = 4'b1001;
    localparam logic [3:0] FN_GT    = 4'b1010;
    localparam logic [3:0] FN_LT    = 4'b1011;

    // Shift unit codes
    localparam logic [3:0] FN_SHR_A = 4'b1100;
    localparam logic [3:0] FN_SHL_A = 4'b1101;
    localparam logic [3:0] FN_SHR_B = 4'b1110;
    localparam logic [3:0] FN_SHL_B = 4'b1111;

    // Unit select carried in the top two bits of the function code
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_t;

    // Values driven on the compare bus when the relation holds
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;
    localparam int CMP_LT = 3;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: turns the unit-select bits of the function code into
// four one-hot unit enables.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel,
    output logic       arith_en,
    output logic       logic_en,
    output logic       cmp_en,
    output logic       shift_en
);

    // Exactly one enable is raised for every select value
    always_comb begin
        arith_en = 1'b0;
        logic_en = 1'b0;
        cmp_en   = 1'b0;
        shift_en = 1'b0;
        unique case (unit_t'(unit_sel))
            UNIT_ARITH: arith_en = 1'b1;
            UNIT_LOGIC: logic_en = 1'b1;
            UNIT_CMP:   cmp_en   = 1'b1;
            UNIT_SHIFT: shift_en = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// alu_top: registered 16-bit ALU with arithmetic, logic, compare and shift
// units. Define ALU_DIV_EN to build the divider behind opcode 0011.
module alu_top
    import alu_pkg::*;
#(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int ARITH_WIDTH = 32,
    parameter int LOGIC_WIDTH = 16,
    parameter int CMP_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [A_WIDTH-1:0]     A,
    input  logic [B_WIDTH-1:0]     B,
    input  logic [3:0]             ALU_FUNC,
    output logic [ARITH_WIDTH-1:0] Arith_OUT,
    output logic                   Carry_OUT,
    output logic [LOGIC_WIDTH-1:0] Logic_OUT,
    output logic [CMP_WIDTH-1:0]   CMP_OUT,
    output logic [SHIFT_WIDTH-1:0] Shift_OUT,
    output logic                   Arith_Flag,
    output logic                   Logic_Flag,
    output logic                   CMP_Flag,
    output logic                   Shift_Flag
);

    logic arith_en;
    logic logic_en;
    logic cmp_en;
    logic shift_en;

    alu_decoder u_dec (
        .unit_sel (ALU_FUNC[3:2]),
        .arith_en (arith_en),
        .logic_en (logic_en),
        .cmp_en   (cmp_en),
        .shift_en (shift_en)
    );

    // Operands zero-extended to the arithmetic width so that the sum,
    // difference and product never lose bits before the carry is taken.
    logic [ARITH_WIDTH-1:0] a_ext;
    logic [ARITH_WIDTH-1:0] b_ext;
    logic [ARITH_WIDTH-1:0] sum;
    logic [ARITH_WIDTH-1:0] diff;
    logic [ARITH_WIDTH-1:0] prod;
    logic [ARITH_WIDTH-1:0] quot;

    assign a_ext = ARITH_WIDTH'(A);
    assign b_ext = ARITH_WIDTH'(B);
    assign sum   = a_ext + b_ext;
    assign diff  = a_ext - b_ext;
    assign prod  = a_ext * b_ext;

`ifdef ALU_DIV_EN
    // Divide by zero returns zero instead of an undefined quotient
    assign quot = (B == '0) ? '0 : ARITH_WIDTH'(A / B);
`else
    assign quot = '0;
`endif

    logic [ARITH_WIDTH-1:0] arith_nxt;
    logic                   carry_nxt;

    // Arithmetic result and carry/borrow/overflow for the current code
    always_comb begin
        arith_nxt = '0;
        carry_nxt = 1'b0;
        case (ALU_FUNC)
            FN_ADD: begin
                arith_nxt = sum;
                carry_nxt = sum[A_WIDTH];
            end
            FN_SUB: begin
                arith_nxt = diff;
                carry_nxt = (a_ext < b_ext);
            end
            FN_MUL: begin
                arith_nxt = prod;
                carry_nxt = |prod[ARITH_WIDTH-1:A_WIDTH];
            end
            FN_DIV: begin
                arith_nxt = quot;
                carry_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Arithmetic unit register; cleared whenever another unit is chosen
    always_ff @(posedge CLK) begin
        if (RST) begin
            Arith_OUT  <= '0;
            Carry_OUT  <= 1'b0;
            Arith_Flag <= 1'b0;
        end else if (arith_en) begin
            Arith_OUT  <= arith_nxt;
            Carry_OUT  <= carry_nxt;
            Arith_Flag <= 1'b1;
        end else begin
            Arith_OUT  <= '0;
            Carry_OUT  <= 1'b0;
            Arith_Flag <= 1'b0;
        end
    end

    logic [LOGIC_WIDTH-1:0] a_log;
    logic [LOGIC_WIDTH-1:0] b_log;
    logic [LOGIC_WIDTH-1:0] logic_nxt;

    assign a_log = LOGIC_WIDTH'(A);
    assign b_log = LOGIC_WIDTH'(B);

    // Bitwise result for the current code
    always_comb begin
        logic_nxt = '0;
        case (ALU_FUNC)
            FN_AND:  logic_nxt = a_log & b_log;
            FN_OR:   logic_nxt = a_log | b_log;
            FN_NAND: logic_nxt = ~(a_log & b_log);
            FN_NOR:  logic_nxt = ~(a_log | b_log);
            default: ;
        endcase
    end

    // Logic unit register
    always_ff @(posedge CLK) begin
        if (RST) begin
            Logic_OUT  <= '0;
            Logic_Flag <= 1'b0;
        end else if (logic_en) begin
            Logic_OUT  <= logic_nxt;
            Logic_Flag <= 1'b1;
        end else begin
            Logic_OUT  <= '0;
            Logic_Flag <= 1'b0;
        end
    end

    logic [CMP_WIDTH-1:0] cmp_nxt;
    logic                 cmp_flag_nxt;

    // Relation code for the current compare, or zero when it fails;
    // NOP leaves both the bus and the flag low.
    always_comb begin
        cmp_nxt      = '0;
        cmp_flag_nxt = 1'b1;
        case (ALU_FUNC)
            FN_NOP: cmp_flag_nxt = 1'b0;
            FN_EQ:  if (a_ext == b_ext) cmp_nxt = CMP_WIDTH'(CMP_EQ);
            FN_GT:  if (a_ext > b_ext)  cmp_nxt = CMP_WIDTH'(CMP_GT);
            FN_LT:  if (a_ext < b_ext)  cmp_nxt = CMP_WIDTH'(CMP_LT);
            default: ;
        endcase
    end

    // Compare unit register
    always_ff @(posedge CLK) begin
        if (RST) begin
            CMP_OUT  <= '0;
            CMP_Flag <= 1'b0;
        end else if (cmp_en) begin
            CMP_OUT  <= cmp_nxt;
            CMP_Flag <= cmp_flag_nxt;
        end else begin
            CMP_OUT  <= '0;
            CMP_Flag <= 1'b0;
        end
    end

    logic [SHIFT_WIDTH-1:0] shift_nxt;

    // One-bit logical shifts, zero-filled and cut to the shift width
    always_comb begin
        shift_nxt = '0;
        case (ALU_FUNC)
            FN_SHR_A: shift_nxt = SHIFT_WIDTH'(A >> 1);
            FN_SHL_A: shift_nxt = SHIFT_WIDTH'({A, 1'b0});
            FN_SHR_B: shift_nxt = SHIFT_WIDTH'(B >> 1);
            FN_SHL_B: shift_nxt = SHIFT_WIDTH'({B, 1'b0});
            default: ;
        endcase
    end

    // Shift unit register
    always_ff @(posedge CLK) begin
        if (RST) begin
            Shift_OUT  <= '0;
            Shift_Flag <= 1'b0;
        end else if (shift_en) begin
            Shift_OUT  <= shift_nxt;
            Shift_Flag <= 1'b1;
        end else begin
            Shift_OUT  <= '0;
            Shift_Flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top; expected result vectors are
// queued as stimulus is driven and compared one edge later.
module tb_alu_top;

    logic        CLK;
    logic        RST;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUNC;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT;
    logic [15:0] Logic_OUT;
    logic [15:0] CMP_OUT;
    logic [15:0] Shift_OUT;
    logic        Arith_Flag;
    logic        Logic_Flag;
    logic        CMP_Flag;
    logic        Shift_Flag;

    alu_top dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUNC   (ALU_FUNC),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Logic_OUT  (Logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .Shift_OUT  (Shift_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .Shift_Flag (Shift_Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef ALU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    // {arith, carry, logic, cmp, shift, flags{A,L,C,S}}
    typedef logic [84:0] vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic        rst;
        vec_t        e;
    } stim_t;

    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [31:0] ar, input logic c,
                                input logic [15:0] lg, input logic [15:0] cm,
                                input logic [15:0] sh, input logic [3:0] fl);
        return {ar, c, lg, cm, sh, fl};
    endfunction

    function automatic vec_t obs();
        return {Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
                Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    endfunction

    function automatic stim_t st(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, input logic rst,
                                 input vec_t e);
        stim_t s;
        s.a = a; s.b = b; s.f = f; s.rst = rst; s.e = e;
        return s;
    endfunction

    // Drives one cycle of stimulus, queues its expectation, then waits
    // until just after the edge that registers it.
    task automatic drive(input stim_t s);
        @(negedge CLK);
        A        = s.a;
        B        = s.b;
        ALU_FUNC = s.f;
        RST      = s.rst;
        sb.push_back(s.e);
        @(posedge CLK);
        #1;
    endtask

    // Independent reference used for random back-to-back traffic
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] f);
        logic [31:0] ea, eb, ar;
        logic        c;
        logic [15:0] lg, cm, sh;
        logic [3:0]  fl;
        ea = {16'h0, a}; eb = {16'h0, b};
        ar = 0; c = 0; lg = 0; cm = 0; sh = 0; fl = 0;
        case (f)
            4'd0:  begin ar = ea + eb; c = (ea + eb) > 32'hFFFF; fl = 4'b1000; end
            4'd1:  begin ar = ea - eb; c = (a < b); fl = 4'b1000; end
            4'd2:  begin ar = ea * eb; c = (ea * eb) > 32'hFFFF; fl = 4'b1000; end
            4'd3:  begin ar = (DIV_ON && b != 0) ? ea / eb : 0; fl = 4'b1000; end
            4'd4:  begin lg = a & b;    fl = 4'b0100; end
            4'd5:  begin lg = a | b;    fl = 4'b0100; end
            4'd6:  begin lg = ~(a & b); fl = 4'b0100; end
            4'd7:  begin lg = ~(a | b); fl = 4'b0100; end
            4'd8:  ;
            4'd9:  begin cm = (a == b) ? 16'd1 : 16'd0; fl = 4'b0010; end
            4'd10: begin cm = (a > b)  ? 16'd2 : 16'd0; fl = 4'b0010; end
            4'd11: begin cm = (a < b)  ? 16'd3 : 16'd0; fl = 4'b0010; end
            4'd12: begin sh = a >> 1; fl = 4'b0001; end
            4'd13: begin sh = a << 1; fl = 4'b0001; end
            4'd14: begin sh = b >> 1; fl = 4'b0001; end
            default: begin sh = b << 1; fl = 4'b0001; end
        endcase
        return mk(ar, c, lg, cm, sh, fl);
    endfunction

    task automatic test_reset();
        stim_t q[$];
        vec_t  got, e;
        q.push_back(st(16'd6, 16'd3, 4'b0000, 1'b1, '0));
        q.push_back(st(16'hFFFF, 16'hFFFF, 4'b0010, 1'b1, '0));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_add();
        stim_t s;
        vec_t  got, e;
        s = st(16'd6, 16'd3, 4'b0000, 1'b0, mk(32'd9, 1'b0, 0, 0, 0, 4'b1000));
        drive(s);
        got = obs();
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h expected %h", got, e);
        end
    endtask

    task automatic test_arith();
        stim_t q[$];
        vec_t  got, e;
        logic [31:0] divq;
        divq = DIV_ON ? 32'd2 : 32'd0;
        q.push_back(st(16'd6, 16'd3, 4'b0001, 1'b0, mk(32'd3, 0, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'd6, 16'd3, 4'b0010, 1'b0, mk(32'd18, 0, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'd6, 16'd3, 4'b0011, 1'b0, mk(divq, 0, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'd5, 16'd0, 4'b0011, 1'b0, mk(32'd0, 0, 0, 0, 0, 4'b1000)));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL arith[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_logic_cmp();
        stim_t q[$];
        vec_t  got, e;
        q.push_back(st(16'd6, 16'd3, 4'b0100, 1'b0, mk(0, 0, 16'h0002, 0, 0, 4'b0100)));
        q.push_back(st(16'd6, 16'd3, 4'b0101, 1'b0, mk(0, 0, 16'h0007, 0, 0, 4'b0100)));
        q.push_back(st(16'd6, 16'd3, 4'b0110, 1'b0, mk(0, 0, 16'hFFFD, 0, 0, 4'b0100)));
        q.push_back(st(16'd6, 16'd3, 4'b0111, 1'b0, mk(0, 0, 16'hFFF8, 0, 0, 4'b0100)));
        q.push_back(st(16'd6, 16'd3, 4'b1001, 1'b0, mk(0, 0, 0, 16'd0, 0, 4'b0010)));
        q.push_back(st(16'd6, 16'd3, 4'b1010, 1'b0, mk(0, 0, 0, 16'd2, 0, 4'b0010)));
        q.push_back(st(16'd6, 16'd3, 4'b1011, 1'b0, mk(0, 0, 0, 16'd0, 0, 4'b0010)));
        q.push_back(st(16'd7, 16'd7, 4'b1001, 1'b0, mk(0, 0, 0, 16'd1, 0, 4'b0010)));
        q.push_back(st(16'd3, 16'd6, 4'b1011, 1'b0, mk(0, 0, 0, 16'd3, 0, 4'b0010)));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL logic_cmp[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_shift();
        stim_t q[$];
        vec_t  got, e;
        q.push_back(st(16'd6, 16'd3, 4'b1100, 1'b0, mk(0, 0, 0, 0, 16'd3, 4'b0001)));
        q.push_back(st(16'd6, 16'd3, 4'b1101, 1'b0, mk(0, 0, 0, 0, 16'd12, 4'b0001)));
        q.push_back(st(16'd6, 16'd3, 4'b1110, 1'b0, mk(0, 0, 0, 0, 16'd1, 4'b0001)));
        q.push_back(st(16'd6, 16'd3, 4'b1111, 1'b0, mk(0, 0, 0, 0, 16'd6, 4'b0001)));
        q.push_back(st(16'h8001, 16'd0, 4'b1101, 1'b0, mk(0, 0, 0, 0, 16'h0002, 4'b0001)));
        q.push_back(st(16'h8001, 16'd0, 4'b1100, 1'b0, mk(0, 0, 0, 0, 16'h4000, 4'b0001)));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL shift[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_carry();
        stim_t q[$];
        vec_t  got, e;
        q.push_back(st(16'hFFFF, 16'hFFFF, 4'b0000, 1'b0,
                       mk(32'h0001FFFE, 1'b1, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'hFFFF, 16'hFFFF, 4'b0010, 1'b0,
                       mk(32'hFFFE0001, 1'b1, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'd3, 16'd6, 4'b0001, 1'b0,
                       mk(32'hFFFFFFFD, 1'b1, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'h0100, 16'h0100, 4'b0010, 1'b0,
                       mk(32'h00010000, 1'b1, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'h00FF, 16'h0101, 4'b0010, 1'b0,
                       mk(32'h0000FFFF, 1'b0, 0, 0, 0, 4'b1000)));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL carry[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_nop_reset_priority();
        stim_t q[$];
        vec_t  got, e;
        q.push_back(st(16'd6, 16'd3, 4'b1000, 1'b0, '0));
        q.push_back(st(16'd6, 16'd3, 4'b0000, 1'b0, mk(32'd9, 0, 0, 0, 0, 4'b1000)));
        q.push_back(st(16'hFFFF, 16'hFFFF, 4'b0000, 1'b1, '0));
        q.push_back(st(16'd6, 16'd3, 4'b0101, 1'b0, mk(0, 0, 16'h0007, 0, 0, 4'b0100)));
        foreach (q[i]) begin
            drive(q[i]);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL nop_rst[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        vec_t  got, e;
        for (int i = 0; i < 48; i++) begin
            s.a   = 16'($urandom());
            s.b   = ($urandom_range(0, 3) == 0) ? s.a : 16'($urandom());
            s.f   = 4'(i % 16);
            if (i >= 16) s.f = 4'($urandom_range(0, 15));
            s.rst = 1'b0;
            s.e   = model(s.a, s.b, s.f);
            drive(s);
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] f=%b a=%h b=%h: got %h expected %h",
                         i, s.f, s.a, s.b, got, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        A        = '0;
        B        = '0;
        ALU_FUNC = '0;
        test_reset();
        test_add();
        test_arith();
        test_logic_cmp();
        test_shift();
        test_carry();
        test_nop_reset_priority();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
